// File: rtl/gesture_sequencer.sv
// ---------------------------------------------------------------------------
// gesture_sequencer
//
// Queues gesture codes for a robotic hand and presents each one on the
// gesture output for a fixed dwell time, back to back, then reports the end
// of the sequence. An abort flushes everything and opens the hand.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   asynchronous, active-high reset
//   cmd_gesture  in   [7:0] requested gesture code
//   cmd_valid    in   command request qualifier
//   cmd_ready    out  queue can accept a command this cycle
//   abort        in   flush queue and return the hand to open (8'h02)
//   gesture      out  [7:0] registered code for the gesture decoder
//   gesture_stb  out  one-cycle pulse when gesture takes a newly issued value
//   busy         out  high while a gesture dwell is running
//   seq_done     out  one-cycle pulse when the last queued dwell expires
//   cmd_err      out  one-cycle pulse after an accepted but illegal code
//   fifo_count   out  [2:0] number of queued entries, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module gesture_sequencer #(
    parameter int DWELL_TICKS = 25000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_gesture,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       abort,
    output logic [7:0] gesture,
    output logic       gesture_stb,
    output logic       busy,
    output logic       seq_done,
    output logic       cmd_err,
    output logic [2:0] fifo_count
);

    localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]  DEPTH_C    = 3'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [25:0] DWELL_LOAD = 26'(DWELL_TICKS - 1);
    localparam logic [7:0]  OPEN_HAND  = 8'h02;

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [25:0]     dwell_cnt;

    logic            accept;
    logic            code_legal;
    logic            push;
    logic            pop;
    logic            dwell_expired;
    logic [AW-1:0]   wr_ptr_next;
    logic [AW-1:0]   rd_ptr_next;

    // A full queue refuses new commands even if an entry leaves this same
    // cycle; abort also closes the door so a flushed queue stays empty.
    assign cmd_ready     = (fifo_count < DEPTH_C) && !abort;
    assign accept        = cmd_valid && cmd_ready;
    assign code_legal    = (cmd_gesture >= 8'h01) && (cmd_gesture <= 8'h0A);
    assign push          = accept && code_legal;
    assign dwell_expired = (state == DWELL) && (dwell_cnt == '0);
    assign pop           = !abort && (fifo_count != 3'd0)
                           && ((state == IDLE) || dwell_expired);
    assign busy          = (state == DWELL);

    // Explicit wrap keeps the pointers correct for any depth, including 1.
    assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    // Queue storage carries no reset; validity is tracked by the pointers
    // and fifo_count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_gesture;
        end
    end

    // Sequencer state, queue bookkeeping and all registered outputs.
    // Abort overrides every other update; otherwise the queue pointers move
    // independently so a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= 3'd0;
            dwell_cnt   <= '0;
            gesture     <= 8'h00;
            gesture_stb <= 1'b0;
            seq_done    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            gesture_stb <= 1'b0;
            seq_done    <= 1'b0;
            cmd_err     <= accept && !code_legal;

            if (abort) begin
                state       <= IDLE;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= 3'd0;
                dwell_cnt   <= '0;
                gesture     <= OPEN_HAND;
                gesture_stb <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr_next;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_next;
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + 3'd1;
                end else if (pop && !push) begin
                    fifo_count <= fifo_count - 3'd1;
                end

                case (state)
                    IDLE: begin
                        if (pop) begin
                            gesture     <= fifo_mem[rd_ptr];
                            gesture_stb <= 1'b1;
                            dwell_cnt   <= DWELL_LOAD;
                            state       <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 26'd1;
                        end else if (pop) begin
                            // Chain straight into the next gesture, no gap.
                            gesture     <= fifo_mem[rd_ptr];
                            gesture_stb <= 1'b1;
                            dwell_cnt   <= DWELL_LOAD;
                        end else begin
                            state    <= IDLE;
                            seq_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/gesture_sequencer.md
GESTURE_SEQUENCER -- requirements
Module: gesture_sequencer

Interface
REQ-001 SHALL have parameter DWELL_TICKS, default 25000000, clocks each gesture is held (0.5 s at 50 MHz); legal range 1..2^26-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue entries; fixed power of two.
REQ-003 SHALL have port clk  in  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_gesture  in  8  requested gesture code.
REQ-006 SHALL have port cmd_valid  in  1  command request qualifier.
REQ-007 SHALL have port cmd_ready  out  1  queue can accept a command this cycle.
REQ-008 SHALL have port abort  in  1  flush queue, return hand open.
REQ-009 SHALL have port gesture  out  8  registered code driven to the gesture decoder.
REQ-010 SHALL have port gesture_stb  out  1  one-cycle pulse when gesture takes a new issued value.
REQ-011 SHALL have port busy  out  1  high while a gesture dwell is running.
REQ-012 SHALL have port seq_done  out  1  one-cycle pulse when the last queued gesture's dwell expires.
REQ-013 SHALL have port cmd_err  out  1  one-cycle pulse for an accepted but illegal code.
REQ-014 SHALL have port fifo_count  out  3  queued entries, 0..FIFO_DEPTH.

Function
REQ-015 SHALL assert cmd_ready combinationally when fifo_count < FIFO_DEPTH and abort is low; no push when full, even with a same-cycle pop.
REQ-016 SHALL accept a command on clk edge with cmd_valid && cmd_ready.
REQ-017 SHALL store only legal codes 8'h01..8'h0A; an accepted code of 8'h00 or >8'h0A SHALL not be queued and SHALL pulse cmd_err the following cycle.
REQ-018 SHALL implement FSM states IDLE and DWELL.
REQ-019 IDLE: when fifo_count>0, pop head, load gesture with it, pulse gesture_stb, load dwell counter with DWELL_TICKS-1, go DWELL; all register updates on the same edge.
REQ-020 DWELL: decrement counter each cycle; at counter==0 with fifo_count>0, pop next entry and reload with no idle cycle between gestures.
REQ-021 DWELL: at counter==0 with empty queue, go IDLE, pulse seq_done, hold gesture at last value.
REQ-022 Each issued gesture SHALL be presented for exactly DWELL_TICKS cycles before the next gesture_stb.
REQ-023 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-024 Queue read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 busy SHALL equal (state==DWELL).
REQ-026 abort high on an edge SHALL empty queue, set state IDLE, set gesture to 8'h02 (open hand), pulse gesture_stb, suppress seq_done; abort takes priority over push, pop and dwell expiry.
REQ-027 Continuous abort SHALL hold cmd_ready low and gesture at 8'h02; gesture_stb SHALL pulse on each abort cycle.
REQ-028 gesture SHALL change only on pop, abort or reset.

Reset
REQ-029 reset high SHALL asynchronously force state IDLE, queue empty, pointers 0, dwell counter 0, gesture 8'h00, gesture_stb/busy/seq_done/cmd_err 0, fifo_count 0.
REQ-030 Reset mid-dwell SHALL discard the queued and active gesture; first edge after deassertion SHALL behave as IDLE with an empty queue.

Verification
REQ-031 DWELL_TICKS=4, push 8'h01 in IDLE -> gesture=8'h01 with gesture_stb one cycle after accept, busy 4 cycles, seq_done pulse, gesture holds 8'h01.
REQ-032 DWELL_TICKS=4, push 8'h01,8'h02,8'h03 back-to-back -> gesture_stb exactly 4 cycles apart, codes in order, single seq_done after 12 busy cycles.
REQ-033 Push 6 codes while dwelling with depth 4 -> cmd_ready low at fifo_count=4, no entry lost or duplicated, order preserved across pointer wrap.
REQ-034 Push 8'h00 and 8'h0B -> cmd_err pulses twice, fifo_count stays 0, gesture unchanged.
REQ-035 Abort during dwell with 3 queued, cmd_valid high same cycle -> fifo_count=0, gesture=8'h02, busy low, no seq_done, command not accepted.
REQ-036 Assert reset mid-dwell for one cycle -> all outputs at reset values immediately, then subsequent push sequences normally.
